// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell: s = a^b^cin, c = majority(a,b,cin).
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// with valid/ready handshakes on operands and result.
//
// state  | meaning
// S_IDLE | waiting for an operand beat (in_ready=1)
// S_RUN  | adding one bit per cycle, cnt counts processed bits
// S_DONE | result presented (out_valid=1) until out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;

  fa u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_next = fa_s;
    end else begin : g_wn
      assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            sum   <= sum_next;
            cout  <= fa_c;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, cout;
  logic [7:0] sum;

  logic       v1_in_valid = 1'b0, v1_out_ready = 1'b0, v1_cin = 1'b0;
  logic [0:0] v1_a = '0, v1_b = '0;
  logic       v1_in_ready, v1_out_valid, v1_cout;
  logic [0:0] v1_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
    .a(v1_a), .b(v1_b), .cin(v1_cin), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
    .sum(v1_sum), .cout(v1_cout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one WIDTH=8 operation from S_IDLE; hammer keeps in_valid high with a changing during the stall.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input logic [8:0] exp, input int stall, input bit hammer, input string nm);
    int n;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a = ~ta; b = $urandom; cin = ~tc;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({nm, "_latency"}, 32'(n), 32'd8);
    check({nm, "_result"}, 32'({cout, sum}), 32'(exp));
    repeat (stall) begin
      in_valid = hammer;
      if (hammer) a = $urandom;
      tick();
      check({nm, "_stall"}, 32'({out_valid, in_ready, cout, sum}), 32'({1'b1, 1'b0, exp}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_release"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  task automatic run_op1(input logic ta, input logic tb, input logic tc, input int stall);
    int n;
    logic [1:0] exp;
    exp = 2'(ta) + 2'(tb) + 2'(tc);
    v1_a = ta; v1_b = tb; v1_cin = tc; v1_in_valid = 1'b1;
    check("w1_in_ready", 32'(v1_in_ready), 32'd1);
    tick();
    v1_in_valid = 1'b0;
    v1_a = ~ta; v1_b = ~tb;
    n = 0;
    while (!v1_out_valid && n < 20) begin
      tick();
      n++;
    end
    check("w1_latency", 32'(n), 32'd1);
    check("w1_result", 32'({v1_cout, v1_sum}), 32'(exp));
    repeat (stall) tick();
    check("w1_hold", 32'({v1_out_valid, v1_cout, v1_sum}), 32'({1'b1, exp}));
    v1_out_ready = 1'b1;
    tick();
    v1_out_ready = 1'b0;
    check("w1_release", 32'({v1_in_ready, v1_out_valid}), 32'b10);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    bit         seen_valid;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

    // Reset state
    #12;
    check("reset_outs", 32'({out_valid, sum, cout, in_ready}), 32'({1'b0, 8'h00, 1'b0, 1'b1}));
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (3) begin
      tick();
      if (out_valid || !in_ready) seen_valid = 1'b1;
    end
    check("post_reset_idle", 32'(seen_valid), 32'd0);

    for (int i = 0; i < 8; i++)
      run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].exp_cout, vecs[i].exp_sum},
              i % 3, 1'b0, $sformatf("vec%0d", i));

    // Stalled result with in_valid hammering
    run_op8(8'h0F, 8'h01, 1'b0, 9'h010, 5, 1'b1, "stall");

    // Reset during the third S_RUN cycle
    a = 8'h55; b = 8'hAA; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrun_reset", 32'({out_valid, sum, cout, in_ready}), 32'({1'b0, 8'h00, 1'b0, 1'b1}));
    tick();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (12) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("abandoned_no_valid", 32'({seen_valid, sum, cout}), 32'd0);
    run_op8(8'h12, 8'h34, 1'b0, 9'h046, 0, 1'b0, "after_reset");

    // Random ops, WIDTH=8
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      run_op8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), $urandom_range(0, 3), 1'b0, "rand8");
    end

    // WIDTH=1: every input combination
    for (int i = 0; i < 8; i++)
      run_op1(1'(i >> 2), 1'(i >> 1), 1'(i), $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
